// File: rtl/fm_pkg.sv
// Shared constants, state encodings and fixed-point helpers for the FM demodulator
// and its sequential divider.
package fm_pkg;

    localparam int QUANT_BITS    = 10;
    localparam int QUARTER_PI    = 804;
    localparam int FM_DEMOD_GAIN = 758;
    localparam int PROD_W        = 64;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIVIDE,
        ANGLE,
        OUTPUT
    } state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FIX
    } div_state_t;

    // Signed divide by 2^QUANT_BITS rounding toward zero: bias negatives before the shift.
    function automatic logic signed [PROD_W-1:0] dequantize(input logic signed [PROD_W-1:0] x);
        logic signed [PROD_W-1:0] bias;
        bias = x[PROD_W-1] ? PROD_W'((1 << QUANT_BITS) - 1) : '0;
        return (x + bias) >>> QUANT_BITS;
    endfunction

endpackage

// File: rtl/div_signed.sv
// Sequential restoring signed divider: WIDTH magnitude iterations followed by one
// sign-fixup cycle; quotient truncates toward zero and is valid while done is high.
module div_signed
    import fm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] dividend,
    input  logic signed [WIDTH-1:0] divisor,
    output logic signed [WIDTH-1:0] quotient,
    output logic                    done
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q, neg_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (start) begin
            // Magnitudes are held unsigned so the most negative value divides correctly.
            state_d = DIV_ITER;
            count_d = '0;
            rem_d   = '0;
            quo_d   = dividend[WIDTH-1] ? -dividend : dividend;
            dvsr_d  = divisor[WIDTH-1] ? -divisor : divisor;
            neg_d   = dividend[WIDTH-1] ^ divisor[WIDTH-1];
        end else begin
            case (state_q)
                DIV_ITER: begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_FIX;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
        end
    end

    assign quotient = neg_q ? -quo_q : quo_q;
    assign done     = (state_q == DIV_FIX);

endmodule

// File: rtl/fm_demod.sv
// FM demodulator: conjugate-multiply consecutive I/Q samples, quantized arctangent
// via a ratio divide, then gain scaling. One sample in flight at a time.
module fm_demod
    import fm_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_in,
    input  logic [DATA_WIDTH-1:0] q_in,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  out_full,
    output logic                  out_wr_en
);

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] cur_i_q, cur_i_d;
    logic signed [DATA_WIDTH-1:0] cur_q_q, cur_q_d;
    logic signed [DATA_WIDTH-1:0] prev_i_q, prev_i_d;
    logic signed [DATA_WIDTH-1:0] prev_q_q, prev_q_d;
    logic signed [DATA_WIDTH-1:0] rr_q, rr_d;
    logic signed [DATA_WIDTH-1:0] dout_c_q, dout_c_d;
    logic signed [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                         r_neg_q, r_neg_d;
    logic                         im_neg_q, im_neg_d;

    logic signed [PROD_W-1:0]     re_full, im_full, ang_prod, gain_prod;
    logic signed [DATA_WIDTH-1:0] r, im, abs_y, num, den, base, angle, dout_c;
    logic signed [DATA_WIDTH-1:0] div_quotient;
    logic                         div_start, div_done;

    always_comb begin
        re_full = PROD_W'(prev_i_q) * PROD_W'(cur_i_q) + PROD_W'(prev_q_q) * PROD_W'(cur_q_q);
        im_full = PROD_W'(prev_i_q) * PROD_W'(cur_q_q) - PROD_W'(prev_q_q) * PROD_W'(cur_i_q);
        r       = DATA_WIDTH'(dequantize(re_full));
        im      = DATA_WIDTH'(dequantize(im_full));
        abs_y   = (im[DATA_WIDTH-1] ? -im : im) + DATA_WIDTH'(1);
        // abs_y >= 1 keeps den strictly positive in both half-planes.
        if (!r[DATA_WIDTH-1]) begin
            num = (r - abs_y) <<< QUANT_BITS;
            den = r + abs_y;
        end else begin
            num = (r + abs_y) <<< QUANT_BITS;
            den = abs_y - r;
        end

        base      = r_neg_q ? DATA_WIDTH'(3 * QUARTER_PI) : DATA_WIDTH'(QUARTER_PI);
        ang_prod  = PROD_W'(QUARTER_PI) * PROD_W'(rr_q);
        angle     = base - DATA_WIDTH'(dequantize(ang_prod));
        if (im_neg_q) begin
            angle = -angle;
        end
        gain_prod = PROD_W'(FM_DEMOD_GAIN) * PROD_W'(angle);
        dout_c    = DATA_WIDTH'(dequantize(gain_prod));
    end

    always_comb begin
        state_d   = state_q;
        cur_i_d   = cur_i_q;
        cur_q_d   = cur_q_q;
        prev_i_d  = prev_i_q;
        prev_q_d  = prev_q_q;
        rr_d      = rr_q;
        dout_c_d  = dout_c_q;
        dout_d    = dout_q;
        r_neg_d   = r_neg_q;
        im_neg_d  = im_neg_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                in_rd_en = !in_empty;
                if (!in_empty) begin
                    cur_i_d = i_in;
                    cur_q_d = q_in;
                    state_d = MULT;
                end
            end
            MULT: begin
                div_start = 1'b1;
                r_neg_d   = r[DATA_WIDTH-1];
                im_neg_d  = im[DATA_WIDTH-1];
                prev_i_d  = cur_i_q;
                prev_q_d  = cur_q_q;
                state_d   = DIVIDE;
            end
            DIVIDE: begin
                if (div_done) begin
                    rr_d    = div_quotient;
                    state_d = ANGLE;
                end
            end
            ANGLE: begin
                dout_c_d = dout_c;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    dout_d    = dout_c_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cur_i_q  <= '0;
            cur_q_q  <= '0;
            prev_i_q <= '0;
            prev_q_q <= '0;
            rr_q     <= '0;
            dout_c_q <= '0;
            dout_q   <= '0;
            r_neg_q  <= 1'b0;
            im_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_i_q  <= cur_i_d;
            cur_q_q  <= cur_q_d;
            prev_i_q <= prev_i_d;
            prev_q_q <= prev_q_d;
            rr_q     <= rr_d;
            dout_c_q <= dout_c_d;
            dout_q   <= dout_d;
            r_neg_q  <= r_neg_d;
            im_neg_q <= im_neg_d;
        end
    end

    // The written value appears on dout in the same cycle as out_wr_en, then is held.
    assign dout = out_wr_en ? dout_c_q : dout_q;

    div_signed #(
        .WIDTH(DATA_WIDTH)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .start    (div_start),
        .dividend (num),
        .divisor  (den),
        .quotient (div_quotient),
        .done     (div_done)
    );

endmodule

// File: tb/tb_fm_demod.sv
// Scoreboard bench for fm_demod: a driver pushes model-predicted outputs on every
// pop and an independent monitor checks each downstream write against them.
module tb_fm_demod;

    localparam int DW   = 32;
    localparam int QP   = 804;
    localparam int GAIN = 758;
    localparam int ONE  = 1024;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] i_in = '0;
    logic [DW-1:0] q_in = '0;
    logic          in_empty = 1'b1;
    logic          in_rd_en;
    logic [DW-1:0] dout;
    logic          out_full = 1'b0;
    logic          out_wr_en;

    fm_demod #(.DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .i_in      (i_in),
        .q_in      (q_in),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .dout      (dout),
        .out_full  (out_full),
        .out_wr_en (out_wr_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        int value;
        int pop_cyc;
        bit lat_chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_pop = 0;
    int   prev_i_m = 0;
    int   prev_q_m = 0;
    bit   rand_full = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: angle of cur*conj(prev) by the ratio approximation, plain integer math.
    function automatic int model(int pi_, int pq_, int ci, int cq);
        longint re_l, im_l;
        int r, im, a, num, den, rr, angle;
        re_l = longint'(pi_) * ci + longint'(pq_) * cq;
        im_l = longint'(pi_) * cq - longint'(pq_) * ci;
        r  = int'(re_l / ONE);
        im = int'(im_l / ONE);
        a  = (im < 0 ? -im : im) + 1;
        if (r >= 0) begin
            num = (r - a) * ONE;
            den = r + a;
        end else begin
            num = (r + a) * ONE;
            den = a - r;
        end
        rr    = num / den;
        angle = (r >= 0 ? QP : 3 * QP) - int'(longint'(QP) * rr / ONE);
        if (im < 0) angle = -angle;
        return int'(longint'(GAIN) * angle / ONE);
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor samples just before the rising edge, after all inputs have settled.
    always @(negedge clock) begin
        #4;
        if (reset && out_wr_en) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: dout=%0d written, expected no write", $signed(dout));
            end else begin
                mon_e = sb.pop_front();
                check("dout", $signed(dout), mon_e.value);
                if (mon_e.lat_chk) check("latency", cyc - mon_e.pop_cyc, DW + 4);
                $display("write: dout=%0d expected=%0d cycle=%0d", $signed(dout), mon_e.value, cyc);
            end
        end
    end

    always @(posedge clock) begin
        if (rand_full) begin
            #1;
            out_full = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic send(input int i, input int q, input bit use_model, input int lit, input bit lat);
        int exp_v;
        bit got;
        got = 1'b0;
        @(negedge clock);
        i_in = i;
        q_in = q;
        in_empty = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            #4;
            if (in_rd_en) begin
                got = 1'b1;
                exp_v = use_model ? model(prev_i_m, prev_q_m, i, q) : lit;
                sb.push_back('{exp_v, cyc, lat});
                last_pop = cyc;
                prev_i_m = i;
                prev_q_m = q;
            end
            @(negedge clock);
        end
        in_empty = 1'b1;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_timeout: in_rd_en=0 after 400 cycles, expected a pop of (%0d,%0d)", i, q);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 600 && sb.size() != 0; k++) @(negedge clock);
        @(negedge clock);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d outputs missing, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        in_empty = 1'b1;
        out_full = 1'b0;
        sb.delete();
        prev_i_m = 0;
        prev_q_m = 0;
        repeat (2) @(negedge clock);
        check("rst_dout", $signed(dout), 0);
        check("rst_wr", int'(out_wr_en), 0);
        check("rst_rd", int'(in_rd_en), 0);
        reset = 1'b1;
    endtask

    initial begin
        int p1, ri, rq;

        // Directed pair: zero prev then identical sample; latency and throughput.
        do_reset();
        send(1024, 0, 1'b0, 1190, 1'b1);
        p1 = last_pop;
        send(1024, 0, 1'b0, 1, 1'b1);
        check("throughput", last_pop - p1, DW + 5);
        drain();

        // Quadrature steps in both directions.
        do_reset();
        send(1024, 0, 1'b0, 1190, 1'b1);
        send(0, 1024, 1'b0, 1190, 1'b1);
        drain();
        do_reset();
        send(1024, 0, 1'b0, 1190, 1'b1);
        send(0, -1024, 1'b0, -1190, 1'b1);
        drain();

        // Downstream backpressure with a sample waiting upstream.
        do_reset();
        out_full = 1'b1;
        send(1024, 0, 1'b0, 1190, 1'b0);
        @(negedge clock);
        i_in = 1024;
        q_in = 0;
        in_empty = 1'b0;
        repeat (40) @(negedge clock);
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            check("hold_wr", int'(out_wr_en), 0);
            check("hold_rd", int'(in_rd_en), 0);
            check("hold_dout", $signed(dout), 0);
        end
        out_full = 1'b0;
        send(1024, 0, 1'b0, 1, 1'b1);
        drain();
        repeat (5) @(negedge clock);
        check("dout_hold", $signed(dout), 1);

        // Upstream starvation between samples keeps prev.
        do_reset();
        send(1000, 300, 1'b1, 0, 1'b1);
        drain();
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("gap_rd", int'(in_rd_en), 0);
            check("gap_wr", int'(out_wr_en), 0);
        end
        send(-700, 900, 1'b1, 0, 1'b1);
        drain();
        do_reset();
        send(1000, 300, 1'b1, 0, 1'b1);
        send(-700, 900, 1'b1, 0, 1'b1);
        drain();

        // Reset while the divider is busy.
        do_reset();
        send(500, -300, 1'b1, 0, 1'b1);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        prev_i_m = 0;
        prev_q_m = 0;
        @(negedge clock);
        check("abort_dout", $signed(dout), 0);
        check("abort_wr", int'(out_wr_en), 0);
        reset = 1'b1;
        repeat (45) @(negedge clock);
        send(1024, 0, 1'b0, 1190, 1'b1);
        drain();

        // Random stream with random gaps and backpressure.
        do_reset();
        rand_full = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ri = int'($urandom_range(0, 4095)) - 2048;
            rq = int'($urandom_range(0, 4095)) - 2048;
            if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 5)) @(negedge clock);
            send(ri, rq, 1'b1, 0, 1'b0);
        end
        drain();
        rand_full = 1'b0;
        @(posedge clock);
        #1;
        out_full = 1'b0;
        repeat (5) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
